// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Moore-style sequencer for a multi-cycle MIPS-subset datapath. Each
// instruction is stepped through fetch, decode, execute, memory and
// write-back. The shared ALU, memory port and register file are driven one
// phase at a time. The block also holds the architectural status flags
// (Z, N) and stalls on the memory ready handshake.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   op, funct         opcode / funct fields of the instruction register
//   alu_zero, alu_neg live ALU zero flag and sign bit
//   mem_ready         memory completes the current access this cycle
//   pc_write*, pc_source, i_or_d, mem_read, mem_write, ir_write,
//   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op
//                     datapath mux selects and enables
//   status_z/n        stored status flags
//   illegal           one-cycle pulse on an unsupported opcode
//   instr_done        one-cycle pulse when an instruction retires
//   state             current state (debug)
// -----------------------------------------------------------------------------
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       status_z,
    output logic       status_n,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_JREG   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BN    = 6'b100101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t state_q, state_d;
    logic   status_z_q, status_z_d;
    logic   status_n_q, status_n_d;
    // ALU flags sampled at the end of RTEXE, committed to status in RTWB
    logic   flag_z_q, flag_z_d;
    logic   flag_n_q, flag_n_d;

    logic is_rtype, is_jr, is_lw, is_sw, is_beq, is_bn, is_j;

    assign is_rtype = (op == OP_RTYPE);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_bn    = (op == OP_BN);
    assign is_j     = (op == OP_J);

    assign state    = state_q;
    assign status_z = status_z_q;
    assign status_n = status_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            status_z_q <= 1'b0;
            status_n_q <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_z_q <= status_z_d;
            status_n_q <= status_n_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        status_z_d    = status_z_q;
        status_n_d    = status_n_q;
        flag_z_d      = flag_z_q;
        flag_n_d      = flag_n_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal       = 1'b0;
        instr_done    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC load only in the cycle the memory delivers
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes PC + (imm << 2) for a possible branch
                alu_src_b = 2'b11;
                if (is_lw || is_sw)       state_d = S_MEMADR;
                else if (is_jr)           state_d = S_JREG;
                else if (is_rtype)        state_d = S_RTEXE;
                else if (is_beq || is_bn) state_d = S_BRANCH;
                else if (is_j)            state_d = S_JUMP;
                else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_RTEXE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                flag_z_d  = alu_zero;
                flag_n_d  = alu_neg;
                state_d   = S_RTWB;
            end
            S_RTWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                status_z_d = flag_z_q;
                status_n_d = flag_n_q;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_source  = 2'b01;
                // bn decides from the stored N flag; beq lets the datapath
                // gate the load with the live zero result
                if (is_bn) pc_write      = status_n_q;
                else       pc_write_cond = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JREG: begin
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Strobes are held low for the whole reset interval so that no write
        // can complete after rst_n falls, even before the state flop clears.
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            illegal       = 1'b0;
            instr_done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       alu_zero;
    logic       alu_neg;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       status_z;
    logic       status_n;
    logic       illegal;
    logic       instr_done;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .status_z(status_z), .status_n(status_n),
        .illegal(illegal), .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one R-type from FETCH with zero wait states; ends back in FETCH.
    task automatic do_rtype(input logic z, input logic n);
        op = 6'b000000; funct = 6'b100000; alu_zero = z; alu_neg = n; mem_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read got %b want 0", mem_read); end
        checks++; if (ir_write !== 1'b0) begin errors++; $display("FAIL rst_ir_write got %b want 0", ir_write); end
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write got %b want 0", pc_write); end
        checks++; if (status_z !== 1'b0 || status_n !== 1'b0) begin errors++; $display("FAIL rst_status got %b%b want 00", status_z, status_n); end
        checks++; if (alu_src_b !== 2'b01) begin errors++; $display("FAIL rst_alu_src_b got %b want 01", alu_src_b); end
        rst_n = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rel_mem_read got %b want 1", mem_read); end
    endtask

    task automatic test_rtype();
        logic [3:0] exp_seq[4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        int done_cnt = 0;
        op = 6'b000000; funct = 6'b100000; alu_zero = 1'b0; alu_neg = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (state !== exp_seq[i]) begin errors++; $display("FAIL rt_state%0d got %0d want %0d", i, state, exp_seq[i]); end
            if (instr_done === 1'b1) done_cnt++;
            if (i == 0) begin
                checks++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin errors++; $display("FAIL rt_fetch_load got %b%b want 11", ir_write, pc_write); end
            end
            if (i == 2) begin
                checks++; if (alu_op !== 2'b10 || alu_src_a !== 1'b1) begin errors++; $display("FAIL rt_exe got op=%b a=%b want 10 1", alu_op, alu_src_a); end
            end
            if (i == 3) begin
                checks++; if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin errors++; $display("FAIL rt_wb got %b%b%b want 110", reg_write, reg_dst, mem_to_reg); end
            end
            step();
        end
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL rt_return got %0d want 0", state); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rt_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_lw_wait();
        logic [3:0] exp_seq[10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [3:0] seq[$];
        int  cyc = 0;
        int  fw = 0;
        int  rw = 0;
        bit  seen_done = 1'b0;
        op = 6'b100011; funct = 6'b000000;
        while (cyc < 40 && !seen_done) begin
            if (state == 4'd0)      mem_ready = (fw >= 2);
            else if (state == 4'd3) mem_ready = (rw >= 3);
            else                    mem_ready = 1'b0;
            #1;
            seq.push_back(state);
            if (state == 4'd0 && !mem_ready) begin
                fw++;
                checks++; if (mem_read !== 1'b1 || ir_write !== 1'b0) begin errors++; $display("FAIL lw_fetch_wait got rd=%b ir=%b want 1 0", mem_read, ir_write); end
            end
            if (state == 4'd3) begin
                if (!mem_ready) rw++;
                checks++; if (mem_read !== 1'b1 || i_or_d !== 1'b1) begin errors++; $display("FAIL lw_memrd got rd=%b iod=%b want 1 1", mem_read, i_or_d); end
            end
            if (state == 4'd4) begin
                checks++; if (reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin errors++; $display("FAIL lw_memwb got %b%b%b want 110", reg_write, mem_to_reg, reg_dst); end
            end
            cyc++;
            if (instr_done === 1'b1) seen_done = 1'b1;
            step();
        end
        checks++; if (!seen_done) begin errors++; $display("FAIL lw_timeout got %0d cycles want done", cyc); end
        checks++; if (cyc !== 10) begin errors++; $display("FAIL lw_latency got %0d want 10", cyc); end
        for (int i = 0; i < 10 && i < seq.size(); i++) begin
            checks++; if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL lw_seq%0d got %0d want %0d", i, seq[i], exp_seq[i]); end
        end
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_return got %0d want 0", state); end
    endtask

    task automatic test_bn();
        do_rtype(1'b1, 1'b1);
        #1;
        checks++; if (status_n !== 1'b1 || status_z !== 1'b1) begin errors++; $display("FAIL bn_flags_set got %b%b want 11", status_z, status_n); end
        op = 6'b100101; alu_neg = 1'b0; alu_zero = 1'b0; mem_ready = 1'b1;
        step(); step();
        #1;
        checks++; if (state !== 4'd8) begin errors++; $display("FAIL bn_state got %0d want 8", state); end
        checks++; if (pc_write !== 1'b1 || pc_source !== 2'b01 || pc_write_cond !== 1'b0) begin errors++; $display("FAIL bn_taken got pw=%b src=%b pwc=%b want 1 01 0", pc_write, pc_source, pc_write_cond); end
        checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL bn_done got %b want 1", instr_done); end
        step();
        #1;
        checks++; if (status_n !== 1'b1) begin errors++; $display("FAIL bn_keeps_flag got %b want 1", status_n); end
        do_rtype(1'b0, 1'b0);
        #1;
        checks++; if (status_n !== 1'b0 || status_z !== 1'b0) begin errors++; $display("FAIL bn_flags_clr got %b%b want 00", status_z, status_n); end
        op = 6'b100101; alu_neg = 1'b1;
        step(); step();
        #1;
        checks++; if (state !== 4'd8 || pc_write !== 1'b0) begin errors++; $display("FAIL bn_not_taken got st=%0d pw=%b want 8 0", state, pc_write); end
        step();
        alu_neg = 1'b0;
    endtask

    task automatic test_beq_jr();
        op = 6'b000100; funct = 6'b000000; mem_ready = 1'b1;
        step(); step();
        #1;
        checks++; if (state !== 4'd8) begin errors++; $display("FAIL beq_state got %0d want 8", state); end
        checks++; if (pc_write_cond !== 1'b1 || alu_op !== 2'b01 || pc_write !== 1'b0) begin errors++; $display("FAIL beq_ctrl got pwc=%b op=%b pw=%b want 1 01 0", pc_write_cond, alu_op, pc_write); end
        step();
        op = 6'b000000; funct = 6'b001000;
        step(); step();
        #1;
        checks++; if (state !== 4'd10) begin errors++; $display("FAIL jr_state got %0d want 10", state); end
        checks++; if (pc_source !== 2'b11 || pc_write !== 1'b1 || reg_write !== 1'b0) begin errors++; $display("FAIL jr_ctrl got src=%b pw=%b rw=%b want 11 1 0", pc_source, pc_write, reg_write); end
        step();
        op = 6'b000010; funct = 6'b000000;
        step(); step();
        #1;
        checks++; if (state !== 4'd9 || pc_source !== 2'b10 || pc_write !== 1'b1) begin errors++; $display("FAIL j_ctrl got st=%0d src=%b pw=%b want 9 10 1", state, pc_source, pc_write); end
        step();
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL j_return got %0d want 0", state); end
    endtask

    task automatic test_illegal();
        op = 6'b111111; mem_ready = 1'b1;
        #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_fetch got %b want 0", illegal); end
        step();
        #1;
        checks++; if (state !== 4'd1 || illegal !== 1'b1) begin errors++; $display("FAIL ill_decode got st=%0d ill=%b want 1 1", state, illegal); end
        checks++; if (reg_write !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL ill_writes got rw=%b mw=%b want 0 0", reg_write, mem_write); end
        step();
        #1;
        checks++; if (state !== 4'd0 || illegal !== 1'b0) begin errors++; $display("FAIL ill_return got st=%0d ill=%b want 0 0", state, illegal); end
    endtask

    task automatic test_sw();
        op = 6'b101011; mem_ready = 1'b1;
        step(); step();
        #1;
        checks++; if (state !== 4'd2 || alu_src_b !== 2'b10 || alu_src_a !== 1'b1) begin errors++; $display("FAIL sw_memadr got st=%0d b=%b a=%b want 2 10 1", state, alu_src_b, alu_src_a); end
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (state !== 4'd5 || mem_write !== 1'b1 || i_or_d !== 1'b1 || instr_done !== 1'b0) begin errors++; $display("FAIL sw_wait got st=%0d mw=%b iod=%b dn=%b want 5 1 1 0", state, mem_write, i_or_d, instr_done); end
        step();
        mem_ready = 1'b1;
        #1;
        checks++; if (state !== 4'd5 || mem_write !== 1'b1 || instr_done !== 1'b1) begin errors++; $display("FAIL sw_ready got st=%0d mw=%b dn=%b want 5 1 1", state, mem_write, instr_done); end
        step();
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_return got %0d want 0", state); end
    endtask

    task automatic test_reset_mid();
        do_rtype(1'b1, 1'b1);
        op = 6'b101011; mem_ready = 1'b1;
        step(); step();
        mem_ready = 1'b0;
        step();
        #1;
        checks++; if (state !== 4'd5 || mem_write !== 1'b1) begin errors++; $display("FAIL mid_pre got st=%0d mw=%b want 5 1", state, mem_write); end
        checks++; if (status_n !== 1'b1) begin errors++; $display("FAIL mid_pre_flag got %b want 1", status_n); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_write !== 1'b0 || state !== 4'd0) begin errors++; $display("FAIL mid_abort got mw=%b st=%0d want 0 0", mem_write, state); end
        checks++; if (status_z !== 1'b0 || status_n !== 1'b0) begin errors++; $display("FAIL mid_flags got %b%b want 00", status_z, status_n); end
        checks++; if (mem_read !== 1'b0 || reg_write !== 1'b0 || instr_done !== 1'b0) begin errors++; $display("FAIL mid_strobes got rd=%b rw=%b dn=%b want 0 0 0", mem_read, reg_write, instr_done); end
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (state !== 4'd0 || mem_read !== 1'b1) begin errors++; $display("FAIL mid_release got st=%0d rd=%b want 0 1", state, mem_read); end
    endtask

    initial begin
        rst_n = 1'b0; op = 6'b000000; funct = 6'b000000;
        alu_zero = 1'b0; alu_neg = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_bn();
        test_beq_jr();
        test_illegal();
        test_sw();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS-subset datapath. It replaces single-cycle decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back, and drives the shared ALU, memory port and register file one phase at a time. It holds the architectural status flags (Z, N) and stalls on a memory ready handshake. It sits between the instruction register opcode/funct fields and the datapath mux/enable controls.

## Interface
Parameters: none (fixed 4-bit state encoding).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  opcode field of the instruction register
- funct  in  6  funct field of the instruction register
- alu_zero  in  1  live ALU zero result
- alu_neg  in  1  live ALU sign bit (result[31])
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load gated by alu_zero in the datapath
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs register
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_dst  out  1  write register: 0 rt, 1 rd
- mem_to_reg  out  1  write data: 0 ALUOut, 1 MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0 PC, 1 A register
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- status_z  out  1  stored Z flag
- status_n  out  1  stored N flag
- illegal  out  1  one-cycle pulse, unsupported opcode
- instr_done  out  1  one-cycle pulse when an instruction retires
- state  out  4  current state (debug/verification)

## Operation
- Decoded instructions: R-type op 000000 (funct 001000 = jr, otherwise ALU op), lw 100011, sw 101011, beq 000100, bn 100101 (branch if status_n), j 000010. Any other op is illegal.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, RTWB 7, BRANCH 8, JUMP 9, JREG 10. Encodings 11-15 are unreachable and return to FETCH on the next clock.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. Holds while mem_ready=0. When mem_ready=1, asserts ir_write=1 and pc_write=1 for that cycle and moves to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes branch target). Next state: lw/sw go to MEMADR; R-type non-jr goes to RTEXE; jr goes to JREG; beq/bn go to BRANCH; j goes to JUMP. An illegal op pulses illegal and returns to FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw goes to MEMRD, sw goes to MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready. On mem_ready it pulses instr_done and goes to FETCH.
- RTEXE: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done. Loads status_z and status_n from the registered ALU result flags captured at the end of RTEXE.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - beq: pc_write_cond=1.
  - bn: pc_write=status_n, pc_write_cond=0.
  - bn does not update the status flags. instr_done pulses.
- JUMP: pc_write=1, pc_source=10, instr_done.
- JREG: pc_write=1, pc_source=11, instr_done.
- Exit: MEMWB, RTWB, BRANCH, JUMP and JREG all return to FETCH.
- Defaults: every output not listed for a state is 0.

## Timing
- Reset (rst_n=0): state=FETCH; status_z=0, status_n=0. All strobes are forced 0 while reset is asserted: pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal, instr_done. Mux selects take their FETCH values.
- Reset asserted mid-instruction aborts it immediately; no write completes after rst_n falls.
- Latency with zero wait states (mem_ready tied 1): lw 5 cycles; sw, R-type 4; beq, bn, j, jr 3; illegal 2. Each wait cycle in FETCH, MEMRD or MEMWR adds one.
- Handshake: mem_read/mem_write stay high and stable until the mem_ready cycle. ir_write and pc_write in FETCH are combinationally gated by mem_ready. mem_ready is ignored in all other states.
- Status update happens on the clock edge leaving RTWB and is visible to a bn fetched afterward. The minimum gap from the R-type's RTWB to the bn's BRANCH is 3 cycles.

## Test plan
- Reset then mem_ready=1, op=000000, funct=100000: state sequence 0,1,6,7,0; ir_write/pc_write high in cycle 0; reg_write=1, reg_dst=1 in RTWB; instr_done pulses once.
- lw with mem_ready low 2 cycles in FETCH and 3 cycles in MEMRD: 10 cycles total; mem_read held, i_or_d=1 during MEMRD; reg_write with mem_to_reg=1 in MEMWB.
- R-type with alu_neg=1 captured, then bn: status_n=1, pc_write=1, pc_source=01 in BRANCH. Repeat with alu_neg=0: pc_write=0.
- beq: BRANCH shows pc_write_cond=1, alu_op=01, pc_write=0. jr: JREG shows pc_source=11, pc_write=1.
- op=111111: state 0,1,0; illegal pulses in DECODE; no reg_write or mem_write.
- Drop rst_n during MEMWR with mem_ready=0: mem_write falls asynchronously, state=0, status flags=0.
